// File: rtl/ahb_sram_sub_pkg.sv
// ahb_sram_sub_pkg
//   Shared AHB-Lite encodings and FSM state type for the SRAM subordinate.
//   Contents: htrans_t, HRESP_OKAY/HRESP_ERROR, HSIZE_WORD, sub_state_t.
package ahb_sram_sub_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    SUB_IDLE = 3'd0,
    SUB_WAIT = 3'd1,
    SUB_DATA = 3'd2,
    SUB_ERR1 = 3'd3,
    SUB_ERR2 = 3'd4
  } sub_state_t;

endpackage

// File: rtl/ahb_sram_bytemem.sv
// ahb_sram_bytemem
//   MEM_WORDS x 32-bit storage, asynchronous read, synchronous byte-strobed write.
//   Contents are intentionally not reset.
// Ports:
//   clk    in   clock
//   we     in   write enable for this edge
//   be     in   byte enables, be[b] covers wdata[8b+7:8b]
//   idx    in   word index (shared by read and write)
//   wdata  in   write data
//   rdata  out  combinational read of mem[idx]
module ahb_sram_bytemem #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [MEM_WORDS];

  // Strobed write: only enabled byte lanes are updated.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/ahb_sram_subordinate.sv
// ahb_sram_subordinate
//   AHB-Lite subordinate serving single-word NONSEQ/SEQ transfers from an
//   internal word-addressed SRAM with per-byte write strobes. Illegal transfers
//   (bad size, misaligned, out of range) get a two-cycle ERROR response and
//   never touch memory.
//   Optional feature macro: AHB_SRAM_SUB_WAIT_STATES_EN -- when defined, each
//   legal transfer is stalled by WAIT_STATES cycles of HREADY=0.
// Ports:
//   clk     in   clock
//   nRST    in   asynchronous reset, active-high (despite the name)
//   HSEL    in   subordinate select
//   HTRANS  in   transfer type
//   HWRITE  in   1 = write
//   HSIZE   in   transfer size, only word is legal
//   HADDR   in   byte address
//   HWDATA  in   write data (data phase)
//   HWSTRB  in   byte strobes (data phase)
//   HREADY  out  transfer complete / global HREADY
//   HRESP   out  0 OKAY, 1 ERROR
//   HRDATA  out  read data, zero outside a read data cycle
module ahb_sram_subordinate
  import ahb_sram_sub_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           MEM_WORDS   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic                  HSEL,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [3:0]            HWSTRB,
  output logic                  HREADY,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int unsigned           IDX_W     = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * 4);

  // Elaboration-time parameter sanity.
  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("ahb_sram_subordinate: DATA_WIDTH must be 32");
  end
  if ((MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_mem_words
    $error("ahb_sram_subordinate: MEM_WORDS must be a power of 2");
  end
  if (WAIT_STATES > 15) begin : g_bad_wait_states
    $error("ahb_sram_subordinate: WAIT_STATES must be 0..15");
  end

  sub_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic                  pend_q, pend_d;
  logic                  hready_q, hready_d;
  logic                  hresp_q, hresp_d;
`ifdef AHB_SRAM_SUB_WAIT_STATES_EN
  logic [3:0]            wcnt_q, wcnt_d;
`endif

  logic                  accept_c;
  logic                  err_c;
  logic [ADDR_WIDTH-1:0] addr_off_c;
  logic [IDX_W-1:0]      idx_c;
  logic                  we_c;
  logic [31:0]           mem_rdata;

  // Address-phase accept: only NONSEQ/SEQ while selected and ready.
  assign accept_c = HSEL && hready_q &&
                    ((htrans_t'(HTRANS) == HTRANS_NONSEQ) ||
                     (htrans_t'(HTRANS) == HTRANS_SEQ));

  // Unsigned offset compare also catches addresses below BASE_ADDR (wrap).
  assign addr_off_c = HADDR - BASE_ADDR;
  assign err_c      = (HSIZE != HSIZE_WORD) || (HADDR[1:0] != 2'b00) ||
                      (addr_off_c >= MEM_BYTES);

  assign idx_c = IDX_W'((addr_q - BASE_ADDR) >> 2);

  // Commit only in a legal write's data cycle.
  assign we_c = (state_q == SUB_DATA) && write_q && pend_q && !err_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    err_d   = err_q;
    pend_d  = pend_q;
`ifdef AHB_SRAM_SUB_WAIT_STATES_EN
    wcnt_d  = wcnt_q;
`endif

    case (state_q)
      SUB_IDLE, SUB_DATA, SUB_ERR2: begin
        state_d = SUB_IDLE;
        pend_d  = 1'b0;
        if (accept_c) begin
          addr_d  = HADDR;
          write_d = HWRITE;
          err_d   = err_c;
          pend_d  = 1'b1;
          if (err_c) begin
            state_d = SUB_ERR1;
          end
`ifdef AHB_SRAM_SUB_WAIT_STATES_EN
          else if (WAIT_STATES != 0) begin
            state_d = SUB_WAIT;
            wcnt_d  = '0;
          end
`endif
          else begin
            state_d = SUB_DATA;
          end
        end
      end
`ifdef AHB_SRAM_SUB_WAIT_STATES_EN
      SUB_WAIT: begin
        if (wcnt_q == 4'(WAIT_STATES - 1)) begin
          state_d = SUB_DATA;
          wcnt_d  = '0;
        end else begin
          wcnt_d  = wcnt_q + 4'd1;
        end
      end
`endif
      SUB_ERR1: begin
        state_d = SUB_ERR2;
      end
      default: begin
        state_d = SUB_IDLE;
        pend_d  = 1'b0;
      end
    endcase

    hready_d = !((state_d == SUB_WAIT) || (state_d == SUB_ERR1));
    hresp_d  = ((state_d == SUB_ERR1) || (state_d == SUB_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  end

  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      state_q  <= SUB_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
`ifdef AHB_SRAM_SUB_WAIT_STATES_EN
      wcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
`ifdef AHB_SRAM_SUB_WAIT_STATES_EN
      wcnt_q   <= wcnt_d;
`endif
    end
  end

  ahb_sram_bytemem #(
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (we_c),
    .be    (HWSTRB),
    .idx   (idx_c),
    .wdata (32'(HWDATA)),
    .rdata (mem_rdata)
  );

  assign HREADY = hready_q;
  assign HRESP  = hresp_q;
  // Async read lets a read directly after a write to the same word see new data.
  assign HRDATA = ((state_q == SUB_DATA) && !write_q) ? DATA_WIDTH'(mem_rdata) : '0;

endmodule
